avl_mm_protocol_monitor: RTL and testbench

Synthesizable, parametrised Avalon-MM slave-side protocol monitor. It sits in parallel with any Avalon slave in the UART/peripheral subsystem and observes the bus without driving it. It tracks outstanding pipelined reads, per-read latency and waitrequest-hold rules. Violations are reported as sticky error flags plus a first-error code and an interrupt pulse, usable both in simulation benches and on FPGA.

---
 rtl/avl_mm_protocol_monitor_pkg.sv | 29 ++
 rtl/avl_mm_protocol_monitor_if.sv | 30 +++
 rtl/avl_mm_protocol_monitor_ts_fifo.sv | 58 +++++
 rtl/avl_mm_protocol_monitor.sv | 165 ++++++++++++++++
 tb/tb_avl_mm_protocol_monitor.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/avl_mm_protocol_monitor_pkg.sv
// Shared types and constants for the Avalon-MM protocol monitor.
package avl_mon_pkg;

  // Bit index of each check inside err_o; reported code is index + 1.
  typedef enum logic [2:0] {
    ERR_RW_BOTH       = 3'd0,
    ERR_HOLD          = 3'd1,
    ERR_RDV_UNDERFLOW = 3'd2,
    ERR_OVERFLOW      = 3'd3,
    ERR_RD_TIMEOUT    = 3'd4,
    ERR_WAIT_TIMEOUT  = 3'd5,
    ERR_BE_ZERO       = 3'd6
  } err_idx_e;

  localparam int ERR_NB     = 7;
  localparam int ERR_CODE_W = 3;

  // Waitrequest-hold tracker states.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_STALLED = 1'b1
  } hold_state_e;

  // Error code reported on first_err_o for a given error bit index.
  function automatic logic [ERR_CODE_W-1:0] err_code(input int idx);
    return ERR_CODE_W'(idx + 1);
  endfunction

endpackage

// File: rtl/avl_mm_protocol_monitor_if.sv
// Avalon-MM slave-side bus bundle with master, slave and passive-monitor views.
interface avl_mm_protocol_monitor_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                write;
  logic                read;
  logic                waitrequest;
  logic                readdatavalid;

  modport master (
    output address, byteenable, writedata, write, read,
    input  waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable, writedata, write, read,
    output waitrequest, readdatavalid
  );

  modport monitor (
    input address, byteenable, writedata, write, read,
    input waitrequest, readdatavalid
  );

endinterface

// File: rtl/avl_mm_protocol_monitor_ts_fifo.sv
// Timestamp FIFO: one entry per outstanding read, holding its acceptance time.
// A push into a full FIFO is honoured only when a pop happens in the same cycle.
module avl_mon_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   avl_clk_i,
  input  logic                   avl_reset_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop && !empty_o;
  assign do_push = push && (!full_o || do_pop);
  assign head_o  = mem[rd_ptr];
  assign count_o = count_q;

  // Storage write.
  // NOTE: the data array is deliberately not reset; the count and pointers
  // decide which entries are valid, and a reset-free array maps to RAM.
  always_ff @(posedge avl_clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge avl_clk_i) begin
    if (avl_reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/avl_mm_protocol_monitor.sv
// Passive Avalon-MM slave-side protocol monitor: checks command hold during
// waitrequest, read pipelining limits, read latency and stall length, and
// reports sticky error flags, the first error code and an interrupt pulse.
module avl_mm_protocol_monitor
  import avl_mon_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int MAX_PENDING  = 4,
  parameter int RD_TIMEOUT   = 64,
  parameter int WAIT_TIMEOUT = 256,
  parameter int TS_W         = 16
) (
  input  logic                         avl_clk_i,
  input  logic                         avl_reset_i,
  avl_mm_protocol_monitor_if.monitor   avl,
  input  logic                         clear_i,
  output logic [ERR_NB-1:0]            err_o,
  output logic [ERR_CODE_W-1:0]        first_err_o,
  output logic                         err_irq_o,
  output logic [$clog2(MAX_PENDING):0] pending_o
);

  localparam int SW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TS_W-1:0] RD_TO   = TS_W'(RD_TIMEOUT);
  localparam logic [SW-1:0]   WAIT_TO = SW'(WAIT_TIMEOUT);

  hold_state_e         state_q, state_d;
  logic [SW-1:0]       stall_cnt_q, stall_cnt_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W/8-1:0] cap_be_q, cap_be_d;
  logic [DATA_W-1:0]   cap_wd_q, cap_wd_d;
  logic                cap_rd_q, cap_rd_d;
  logic                cap_wr_q, cap_wr_d;

  logic [TS_W-1:0]       ts_now;
  logic [TS_W-1:0]       head_ts;
  logic [TS_W-1:0]       head_age;
  logic                  fifo_full, fifo_empty;
  logic                  head_flagged_q;
  logic                  rd_acc;
  logic [ERR_NB-1:0]     viol;
  logic [ERR_NB-1:0]     err_d;
  logic [ERR_CODE_W-1:0] viol_code;

  assign rd_acc   = avl.read && !avl.waitrequest;
  assign head_age = ts_now - head_ts;

  avl_mon_ts_fifo #(.DEPTH(MAX_PENDING), .WIDTH(TS_W)) u_ts_fifo (
    .avl_clk_i   (avl_clk_i),
    .avl_reset_i (avl_reset_i),
    .push        (rd_acc),
    .pop         (avl.readdatavalid),
    .push_data   (ts_now),
    .head_o      (head_ts),
    .count_o     (pending_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Free-running timestamp; wrap-around is harmless since ages are modular.
  always_ff @(posedge avl_clk_i) begin
    if (avl_reset_i) ts_now <= '0;
    else             ts_now <= ts_now + TS_W'(1);
  end

  // Hold tracker next state: capture the command on the first stalled cycle.
  // NOTE: every variable is given a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    cap_addr_d  = cap_addr_q;
    cap_be_d    = cap_be_q;
    cap_wd_d    = cap_wd_q;
    cap_rd_d    = cap_rd_q;
    cap_wr_d    = cap_wr_q;
    unique case (state_q)
      ST_IDLE: begin
        stall_cnt_d = '0;
        if ((avl.read || avl.write) && avl.waitrequest) begin
          state_d     = ST_STALLED;
          stall_cnt_d = SW'(1);
          cap_addr_d  = avl.address;
          cap_be_d    = avl.byteenable;
          cap_wd_d    = avl.writedata;
          cap_rd_d    = avl.read;
          cap_wr_d    = avl.write;
        end
      end
      ST_STALLED: begin
        if (!avl.waitrequest) begin
          state_d     = ST_IDLE;
          stall_cnt_d = '0;
        end else if (stall_cnt_q != WAIT_TO) begin
          stall_cnt_d = stall_cnt_q + SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Hold tracker registers.
  always_ff @(posedge avl_clk_i) begin
    if (avl_reset_i) begin
      state_q     <= ST_IDLE;
      stall_cnt_q <= '0;
      cap_addr_q  <= '0;
      cap_be_q    <= '0;
      cap_wd_q    <= '0;
      cap_rd_q    <= 1'b0;
      cap_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      cap_addr_q  <= cap_addr_d;
      cap_be_q    <= cap_be_d;
      cap_wd_q    <= cap_wd_d;
      cap_rd_q    <= cap_rd_d;
      cap_wr_q    <= cap_wr_d;
    end
  end

  // Per-cycle violation detection and lowest-code selection.
  always_comb begin
    viol = '0;
    viol[ERR_RW_BOTH] = avl.read && avl.write;
    viol[ERR_HOLD] = (state_q == ST_STALLED) &&
                     ((avl.address != cap_addr_q) || (avl.byteenable != cap_be_q) ||
                      (avl.read != cap_rd_q) || (avl.write != cap_wr_q) ||
                      (cap_wr_q && (avl.writedata != cap_wd_q)));
    viol[ERR_RDV_UNDERFLOW] = avl.readdatavalid && fifo_empty;
    viol[ERR_OVERFLOW]      = rd_acc && fifo_full && !avl.readdatavalid;
    viol[ERR_RD_TIMEOUT]    = !fifo_empty && !head_flagged_q && (head_age > RD_TO);
    viol[ERR_WAIT_TIMEOUT]  = (state_q == ST_STALLED) && (stall_cnt_q == WAIT_TO);
    viol[ERR_BE_ZERO]       = (avl.read || avl.write) && (avl.byteenable == '0);
    viol_code = '0;
    for (int i = ERR_NB - 1; i >= 0; i--) begin
      if (viol[i]) viol_code = err_code(i);
    end
    err_d = clear_i ? '0 : (err_o | viol);
  end

  // Read timeout is one-shot per head entry; a pop exposes a fresh head.
  always_ff @(posedge avl_clk_i) begin
    if (avl_reset_i)                             head_flagged_q <= 1'b0;
    else if (avl.readdatavalid && !fifo_empty)   head_flagged_q <= 1'b0;
    else if (viol[ERR_RD_TIMEOUT])               head_flagged_q <= 1'b1;
  end

  // Sticky error flags, first-error code and rising-edge interrupt.
  always_ff @(posedge avl_clk_i) begin
    if (avl_reset_i) begin
      err_o       <= '0;
      first_err_o <= '0;
      err_irq_o   <= 1'b0;
    end else begin
      err_o     <= err_d;
      err_irq_o <= |(err_d & ~err_o);
      if (clear_i)                  first_err_o <= '0;
      else if (first_err_o == '0)   first_err_o <= viol_code;
    end
  end

endmodule

// File: tb/tb_avl_mm_protocol_monitor.sv
// Directed bench for avl_mm_protocol_monitor with hand-computed expectations.
module tb_avl_mm_protocol_monitor;
  import avl_mon_pkg::*;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [6:0] err;
  logic [2:0] first_err;
  logic       irq;
  logic [2:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  avl_mm_protocol_monitor_if #(.ADDR_W(14), .DATA_W(32)) avl ();

  avl_mm_protocol_monitor #(
    .ADDR_W(14), .DATA_W(32), .MAX_PENDING(4),
    .RD_TIMEOUT(64), .WAIT_TIMEOUT(256), .TS_W(16)
  ) dut (
    .avl_clk_i   (clk),
    .avl_reset_i (rst),
    .avl         (avl),
    .clear_i     (clear),
    .err_o       (err),
    .first_err_o (first_err),
    .err_irq_o   (irq),
    .pending_o   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    avl.read          = 1'b0;
    avl.write         = 1'b0;
    avl.waitrequest   = 1'b0;
    avl.readdatavalid = 1'b0;
    avl.byteenable    = 4'hF;
    avl.address       = 14'h0;
    avl.writedata     = 32'h0;
    clear             = 1'b0;
  endtask

  initial begin
    idle_bus();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_err", 32'(err), 32'h0);
    check("reset_first", 32'(first_err), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_pending", 32'(pending), 32'h0);

    // Three pipelined reads, responses three cycles later.
    avl.read = 1'b1; avl.address = 14'h20;
    tick(); check("pipe_pend1", 32'(pending), 32'd1);
    avl.address = 14'h24;
    tick(); check("pipe_pend2", 32'(pending), 32'd2);
    avl.address = 14'h28;
    tick(); check("pipe_pend3", 32'(pending), 32'd3);
    avl.read = 1'b0;
    tick(); tick();
    check("pipe_hold3", 32'(pending), 32'd3);
    avl.readdatavalid = 1'b1;
    tick(); check("pipe_pop2", 32'(pending), 32'd2);
    tick(); check("pipe_pop1", 32'(pending), 32'd1);
    tick(); check("pipe_pop0", 32'(pending), 32'd0);
    avl.readdatavalid = 1'b0;
    check("pipe_err", 32'(err), 32'h0);

    // Address changes while stalled by waitrequest.
    avl.read = 1'b1; avl.waitrequest = 1'b1; avl.address = 14'h10;
    tick(); check("hold_c0_err", 32'(err), 32'h0);
    tick(); check("hold_c1_err", 32'(err), 32'h0);
    avl.address = 14'h14;
    tick();
    check("hold_err", 32'(err), 32'h02);
    check("hold_first", 32'(first_err), 32'd2);
    check("hold_irq", 32'(irq), 32'd1);
    avl.read = 1'b0; avl.waitrequest = 1'b0;
    tick();
    check("hold_irq_once", 32'(irq), 32'd0);
    check("hold_sticky", 32'(err), 32'h02);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("hold_clr_err", 32'(err), 32'h0);
    check("hold_clr_first", 32'(first_err), 32'd0);

    // Overflow: five reads accepted with no response.
    avl.read = 1'b1; avl.address = 14'h40;
    repeat (4) tick();
    check("ovf_pend4", 32'(pending), 32'd4);
    check("ovf_noerr", 32'(err), 32'h0);
    tick();
    check("ovf_err", 32'(err), 32'h08);
    check("ovf_first", 32'(first_err), 32'd4);
    check("ovf_sat", 32'(pending), 32'd4);
    avl.readdatavalid = 1'b1;
    tick();
    check("full_pushpop_pend", 32'(pending), 32'd4);
    check("full_pushpop_err", 32'(err), 32'h08);
    check("full_pushpop_irq", 32'(irq), 32'd0);
    avl.read = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ovf_clr_err", 32'(err), 32'h0);
    check("ovf_drain3", 32'(pending), 32'd3);
    repeat (3) tick();
    avl.readdatavalid = 1'b0;
    check("ovf_drain0", 32'(pending), 32'd0);

    // Read timeout: accepted at cycle 0, flagged when age reaches 65.
    avl.read = 1'b1;
    tick();
    avl.read = 1'b0;
    repeat (64) tick();
    check("to_age64", 32'(err), 32'h0);
    tick();
    check("to_err", 32'(err), 32'h10);
    check("to_first", 32'(first_err), 32'd5);
    check("to_irq", 32'(irq), 32'd1);
    tick();
    check("to_irq_once", 32'(irq), 32'd0);
    avl.readdatavalid = 1'b1;
    tick();
    avl.readdatavalid = 1'b0;
    check("to_late_pop", 32'(pending), 32'd0);
    check("to_late_err", 32'(err), 32'h10);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("to_clr", 32'(err), 32'h0);

    // Read and write together with zero byteenable.
    avl.read = 1'b1; avl.write = 1'b1; avl.byteenable = 4'h0;
    tick();
    check("rwbe_err", 32'(err), 32'h41);
    check("rwbe_first", 32'(first_err), 32'd1);
    check("rwbe_irq", 32'(irq), 32'd1);
    avl.read = 1'b0; avl.write = 1'b0; avl.byteenable = 4'hF;
    avl.readdatavalid = 1'b1; clear = 1'b1;
    tick();
    avl.readdatavalid = 1'b0; clear = 1'b0;
    check("rwbe_clr_err", 32'(err), 32'h0);
    check("rwbe_clr_first", 32'(first_err), 32'd0);
    check("rwbe_pend", 32'(pending), 32'd0);

    // Reset with two reads outstanding, then a stray readdatavalid.
    avl.read = 1'b1;
    tick(); tick();
    check("rst_pend2", 32'(pending), 32'd2);
    avl.read = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pend0", 32'(pending), 32'd0);
    avl.readdatavalid = 1'b1;
    tick();
    avl.readdatavalid = 1'b0;
    check("rst_udf_err", 32'(err), 32'h04);
    check("rst_udf_first", 32'(first_err), 32'd3);
    check("rst_udf_pend", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
